// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that feeds a UART transmitter one byte at a time.
// A host side pushes bytes through wr_en/wr_data and sees full/empty/count/overflow.
// A transmitter side receives start/txin, answers with txdone, and then a
// fixed idle gap runs before the next byte is launched.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   wr_en, wr_data    host write strobe and byte
//   full, empty       registered FIFO status flags
//   count             registered number of stored bytes (0..DEPTH)
//   overflow          one-cycle pulse after a write was rejected while full
//   start             one-cycle launch pulse to the transmitter
//   txin              byte presented to the transmitter, held until the next pop
//   txdone            transmitter completion pulse
//   busy              high whenever the launcher is not idle

module uart_tx_feeder #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int GAP_CYCLES = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          start,
    output logic [7:0]    txin,
    input  logic          txdone,
    output logic          busy
);

    // Gap counter only needs to hold GAP_CYCLES-1.
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        GAP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nxt;
    logic          full_q;
    logic          empty_q;
    logic          ovf_q;
    logic [7:0]    txin_q;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_nxt;
    logic          push;
    logic          pop;

    // A full FIFO rejects the write even when a pop frees a slot this cycle,
    // so acceptance depends only on the registered flag.
    assign push = wr_en & ~full_q;

    // Launcher: pops only from IDLE, so at most one byte is ever in flight.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_q;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty_q) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (txdone) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_q - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        unique case ({push, pop})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gap_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            txin_q  <= 8'h00;
        end else begin
            state   <= state_nxt;
            gap_q   <= gap_nxt;
            cnt     <= cnt_nxt;
            // Flags come from the next count so they always agree with count.
            full_q  <= (cnt_nxt == DEPTH_C);
            empty_q <= (cnt_nxt == '0);
            ovf_q   <= wr_en & full_q;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                txin_q <= mem[rd_ptr];
            end
        end
    end

    // Storage has no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = cnt;
    assign overflow = ovf_q;
    assign start    = (state == LAUNCH);
    assign txin     = txin_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed and randomized checks of uart_tx_feeder against
// a queue-and-timestamp model of the feeder.

module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int G     = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          txdone = 1'b0;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          start;
    logic [7:0]    txin;
    logic          busy;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .GAP_CYCLES (G)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .start    (start),
        .txin     (txin),
        .txdone   (txdone),
        .busy     (busy)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the queue holds stored bytes; the launcher is described by
    // the cycle a byte launches and the first cycle it may pop again.
    logic [7:0] q[$];
    bit         mvalid = 1'b0;
    bit         inflight = 1'b0;
    int         launch_at = 0;
    int         ready_at = 0;
    logic [7:0] txin_m = 8'h00;
    bit         ovf_m = 1'b0;
    int         cyc = 0;
    bit         can_pop;
    bit         acc;

    // Launch log taken from the DUT for order/latency checks.
    logic [7:0] sent[$];
    int         sent_cyc[$];

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            inflight = 1'b0;
            ready_at = cyc + 1;
            txin_m   = 8'h00;
            ovf_m    = 1'b0;
            mvalid   = 1'b1;
        end else if (mvalid) begin
            can_pop = !inflight && (cyc >= ready_at) && (q.size() > 0);
            acc     = wr_en && (q.size() < DEPTH);
            ovf_m   = wr_en && (q.size() >= DEPTH);
            if (inflight && (cyc > launch_at) && txdone) begin
                inflight = 1'b0;
                ready_at = cyc + 1 + G;
            end
            if (can_pop) begin
                txin_m    = q.pop_front();
                inflight  = 1'b1;
                launch_at = cyc + 1;
            end
            if (acc) q.push_back(wr_data);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("count", 32'(count), 32'(q.size()));
            check("full", 32'(full), 32'(q.size() == DEPTH));
            check("empty", 32'(empty), 32'(q.size() == 0));
            check("overflow", 32'(overflow), 32'(ovf_m));
            check("start", 32'(start), 32'(inflight && cyc == launch_at));
            check("busy", 32'(busy), 32'(inflight || cyc < ready_at));
            check("txin", 32'(txin), 32'(txin_m));
        end
        if (start === 1'b1) begin
            sent.push_back(txin);
            sent_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        wr_en  = 1'b0;
        txdone = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic done_pulse();
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
    endtask

    task automatic wait_sent(input int n, input string name);
        int k = 0;
        while (sent.size() < n && k < 200) begin
            tick();
            k++;
        end
        if (sent.size() < n) check(name, 32'(sent.size()), 32'(n));
    endtask

    initial begin
        int n0;
        int w;
        int t;
        int base;
        int errs;
        int wp;
        int dp;

        do_reset();
        tick();
        @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(start), 0);
        check("rst_txin", 32'(txin), 32'h00);
        check("rst_ovf", 32'(overflow), 0);
        tick();

        // Single byte latency, gap timing, spurious txdone in GAP and IDLE.
        n0 = sent.size();
        w  = cyc;
        write(8'hA5);
        wait_sent(n0 + 1, "a5_timeout");
        check("a5_lat", 32'(sent_cyc[n0] - w), 2);
        check("a5_data", 32'(sent[n0]), 32'hA5);
        write(8'h55);
        write(8'h77);
        t = cyc;
        done_pulse();
        wait_sent(n0 + 2, "b55_timeout");
        check("gap_lat", 32'(sent_cyc[n0 + 1] - t), G + 2);
        check("b55_data", 32'(sent[n0 + 1]), 32'h55);
        tick();
        tick();
        t = cyc;
        done_pulse();
        tick();
        tick();
        done_pulse();
        wait_sent(n0 + 3, "b77_timeout");
        check("gap_lat_spur", 32'(sent_cyc[n0 + 2] - t), G + 2);
        check("b77_data", 32'(sent[n0 + 2]), 32'h77);
        tick();
        done_pulse();
        repeat (G + 5) tick();
        done_pulse();
        repeat (3) tick();
        @(negedge clk);
        check("idle_spur_busy", 32'(busy), 0);
        check("idle_spur_sent", 32'(sent.size()), 32'(n0 + 3));

        // Fill, order, overflow and write rejected alongside a pop.
        tick();
        do_reset();
        base = sent.size();
        for (int i = 0; i < 16; i++) write(8'(i));
        @(negedge clk);
        check("fill_count15", 32'(count), 15);
        check("fill_full0", 32'(full), 0);
        write(8'h10);
        @(negedge clk);
        check("fill_count16", 32'(count), 16);
        check("fill_full1", 32'(full), 1);
        write(8'hFF);
        @(negedge clk);
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_count", 32'(count), 16);
        tick();
        t = cyc;
        done_pulse();
        repeat (G) tick();
        write(8'hFF);
        @(negedge clk);
        check("simul_ovf", 32'(overflow), 1);
        check("simul_count15", 32'(count), 15);
        for (int k = 1; k <= 16; k++) begin
            wait_sent(base + k + 1, "drain_timeout");
            tick();
            done_pulse();
        end
        check("order_len", 32'(sent.size() - base), 17);
        errs = 0;
        for (int i = 0; i < 17; i++) begin
            if (base + i < sent.size() && sent[base + i] !== 8'(i)) errs++;
        end
        check("order_bytes", 32'(errs), 0);

        // Write coinciding with a pop at count 5.
        repeat (G + 4) tick();
        do_reset();
        for (int i = 0; i < 6; i++) write(8'(8'h20 + i));
        @(negedge clk);
        check("c5_count", 32'(count), 5);
        tick();
        done_pulse();
        repeat (G) tick();
        write(8'hC3);
        @(negedge clk);
        check("c5_simul", 32'(count), 5);

        // Reset in WAIT_DONE with three queued bytes.
        tick();
        do_reset();
        for (int i = 0; i < 4; i++) write(8'(8'h40 + i));
        tick();
        @(negedge clk);
        check("mid_count3", 32'(count), 3);
        check("mid_busy", 32'(busy), 1);
        tick();
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_start", 32'(start), 0);
        n0 = sent.size();
        tick();
        done_pulse();
        repeat (20) tick();
        check("mid_no_start", 32'(sent.size()), 32'(n0));

        // Randomized traffic with varying write/done rates and rare resets.
        for (int blk = 0; blk < 6; blk++) begin
            wp = 10 + blk * 15;
            dp = 30 - blk * 4;
            repeat (500) begin
                wr_en   = ($urandom_range(99) < wp);
                wr_data = 8'($urandom);
                txdone  = ($urandom_range(99) < dp);
                rst     = ($urandom_range(999) == 0);
                tick();
            end
        end
        wr_en  = 1'b0;
        txdone = 1'b0;
        rst    = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
